// File: rtl/column_mac_pkg.sv
// Shared types and sign-magnitude helpers for the column MAC engine.
// COLUMN_MAC_SAT_EN selects saturating output encode; otherwise lanes wrap.
package column_mac_pkg;

   localparam int VAL_W   = 16;
   localparam int FRAC_W  = 10;
   localparam int COLS    = 8;
   localparam int ACCW    = 2*VAL_W + $clog2(COLS);
   localparam int MAG_MAX = 2**(VAL_W-1) - 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic             ovf;
      logic [VAL_W-1:0] sm;
   } enc_t;

   // -0 (0x8000) decodes to plain 0 because negating a zero magnitude is zero.
   function automatic logic signed [VAL_W-1:0] sm_to_tc(input logic [VAL_W-1:0] sm);
      logic signed [VAL_W-1:0] mag;
      mag = signed'({1'b0, sm[VAL_W-2:0]});
      return sm[VAL_W-1] ? -mag : mag;
   endfunction

   function automatic enc_t tc_to_sm_shift(input logic signed [ACCW-1:0] acc,
                                           input int                      frac);
      logic [ACCW-1:0]  mag;
      logic [ACCW-1:0]  shifted;
      logic [VAL_W-2:0] out_mag;
      enc_t             r;
      mag     = acc[ACCW-1] ? ($unsigned(~acc) + 1'b1) : $unsigned(acc);
      shifted = mag >> frac;
      r.ovf   = (shifted > ACCW'(MAG_MAX));
`ifdef COLUMN_MAC_SAT_EN
      out_mag = r.ovf ? '1 : shifted[VAL_W-2:0];
`else
      out_mag = shifted[VAL_W-2:0];
`endif
      // a zero magnitude never carries the sign bit
      r.sm    = {acc[ACCW-1] && (out_mag != '0), out_mag};
      return r;
   endfunction

endpackage

// File: rtl/column_mac_engine_lane.sv
// One MAC lane: product register, wide accumulator, sign-magnitude output encode.
// Latency: product one cycle after en, accumulated the cycle after; no backpressure.
// Backpressure: none; the engine gates en and clr.
module mac_lane
   import column_mac_pkg::*;
#(
   parameter int n    = VAL_W,
   parameter int FRAC = FRAC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [n-1:0] x,
   input  logic [n-1:0] w,
   output logic [n-1:0] y,
   output logic         ovf
);

   logic signed [2*n-1:0]  prod_d, prod_q;
   logic                   pv_d, pv_q;
   logic signed [ACCW-1:0] acc_d, acc_q;
   enc_t                   enc;

   always_comb begin
      prod_d = prod_q;
      pv_d   = en;
      acc_d  = acc_q;
      if (en) begin
         prod_d = sm_to_tc(x) * sm_to_tc(w);
      end
      if (clr) begin
         acc_d = '0;
      end else if (pv_q) begin
         acc_d = acc_q + ACCW'(prod_q);
      end
      enc = tc_to_sm_shift(acc_q, FRAC);
      y   = enc.sm;
      ovf = enc.ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         pv_q   <= 1'b0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         pv_q   <= pv_d;
         acc_q  <= acc_d;
      end
   end

endmodule

// File: rtl/column_mac_engine.sv
// Walks S ROM columns, multiply-accumulating one activation per column into N lanes.
// Latency: start + S handshakes + drain + 1 cycle to y_valid; stalls follow x_valid gaps.
// Backpressure: x_ready only in RUN; result held in DONE until y_ready.
module column_mac_engine
   import column_mac_pkg::*;
#(
   parameter int N         = 8,
   parameter int S         = COLS,
   parameter int n         = VAL_W,
   parameter int addrwidth = 2,
   parameter int FRAC      = FRAC_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [n-1:0]         x_in,
   input  logic                 x_valid,
   output logic                 x_ready,
   output logic [addrwidth:0]   addr,
   input  logic [N*n-1:0]       W,
   output logic [N*n-1:0]       y,
   output logic                 y_valid,
   input  logic                 y_ready,
   output logic                 busy,
   output logic                 ovf
);

   localparam logic [addrwidth:0] LAST_COL = (addrwidth+1)'(S-1);

   state_t             state_d, state_q;
   logic [addrwidth:0] col_d, col_q;
   logic               hs;
   logic               clr;
   logic [n-1:0]       lane_y   [N];
   logic [N-1:0]       lane_ovf;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      x_ready = 1'b0;
      addr    = '0;
      y_valid = 1'b0;
      busy    = (state_q != IDLE);
      clr     = 1'b0;
      hs      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               col_d   = '0;
               clr     = 1'b1;
            end
         end
         RUN: begin
            x_ready = 1'b1;
            addr    = col_q;
            hs      = x_valid;
            if (hs) begin
               col_d = col_q + 1'b1;
               if (col_q == LAST_COL) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            y_valid = 1'b1;
            if (y_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_lane
      mac_lane #(.n(n), .FRAC(FRAC)) u_lane (
         .clk  (clk),
         .rst_n(rst_n),
         .clr  (clr),
         .en   (hs),
         .x    (x_in),
         .w    (W[j*n +: n]),
         .y    (lane_y[j]),
         .ovf  (lane_ovf[j])
      );
      // result is only exposed while flagged valid, so partial sums never leak
      assign y[j*n +: n] = y_valid ? lane_y[j] : '0;
   end

   assign ovf = y_valid && (|lane_ovf);

endmodule

// File: tb/tb_column_mac_engine.sv
// Directed bench for column_mac_engine: fixed ROM images and activation vectors
// with hand-computed lane results, handshake timing, stalls, and reset abort.
module tb_column_mac_engine;

   localparam int N  = 8;
   localparam int S  = 8;
   localparam int VW = 16;
   localparam int AW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [VW-1:0]     x_in = '0;
   logic              x_valid = 1'b0;
   logic              x_ready;
   logic [AW:0]       addr;
   logic [N*VW-1:0]   W;
   logic [N*VW-1:0]   y;
   logic              y_valid;
   logic              y_ready = 1'b0;
   logic              busy;
   logic              ovf;

   logic [N*VW-1:0]   rom [8];
   logic [VW-1:0]     xv  [8];
   logic [N*VW-1:0]   y_got;
   logic              ovf_got;
   logic [N*VW-1:0]   exp_y;
   logic              exp_ovf;
   int                n_chk  = 0;
   int                n_pass = 0;
   int                n_fail = 0;

   always #5 clk = ~clk;

   assign W = rom[addr];

   column_mac_engine #(.N(N), .S(S), .n(VW), .addrwidth(AW), .FRAC(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .x_valid(x_valid),
      .x_ready(x_ready), .addr(addr), .W(W), .y(y), .y_valid(y_valid),
      .y_ready(y_ready), .busy(busy), .ovf(ovf)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete pass from start pulse to result handshake, driven at negedges.
   task automatic run_pass(input bit gaps, input int hold);
      logic [N*VW-1:0] y0;
      logic            o0;
      bit              stable;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < S; c++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               x_valid = 1'b0;
               x_in    = 16'($urandom);
               start   = 1'b1;
               @(negedge clk);
            end
            start = 1'b0;
         end
         x_valid = 1'b1;
         x_in    = xv[c];
         check("run_addr", 128'({x_ready, addr}), 128'({1'b1, 3'(c)}));
         @(negedge clk);
      end
      x_valid = 1'b0;
      x_in    = 16'($urandom);
      if (hold == 0) y_ready = 1'b1;
      check("drain", 128'({busy, y_valid}), 128'(2'b10));
      @(negedge clk);
      check("y_valid_rise", 128'({busy, y_valid}), 128'(2'b11));
      y0 = y; o0 = ovf; stable = 1'b1;
      repeat (hold) begin
         start = 1'b1;
         @(negedge clk);
         if (y !== y0 || ovf !== o0 || y_valid !== 1'b1) stable = 1'b0;
      end
      start = 1'b0;
      if (hold > 0) check("hold_stable", 128'(stable), 128'(1'b1));
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
      check("back_idle", 128'({busy, y_valid, x_ready}), 128'(3'b000));
      y_got   = y0;
      ovf_got = o0;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_ctl", 128'({x_ready, y_valid, busy, ovf, addr}), 128'(0));
      check("rst_y", y, 128'(0));
      @(negedge clk); rst_n = 1'b1;

      // alternating -1/+1 ROM, x = +1 everywhere -> all lanes cancel
      for (int r = 0; r < 8; r++) rom[r] = (r % 2 == 0) ? {N{16'h8400}} : {N{16'h0400}};
      for (int c = 0; c < 8; c++) xv[c] = 16'h0400;
      run_pass(1'b0, 0);
      check("cancel_y", y_got, {N{16'h0000}});
      check("cancel_ovf", 128'(ovf_got), 128'(1'b0));

      // x tracks ROM sign -> every product +1, sum +8.0
      for (int c = 0; c < 8; c++) xv[c] = (c % 2 == 0) ? 16'h8400 : 16'h0400;
      run_pass(1'b0, 0);
      check("plus8_y", y_got, {N{16'h2000}});
      check("plus8_ovf", 128'(ovf_got), 128'(1'b0));

      // 31.999 * 1.0 * 8 = 0x3FFF8 magnitude -> overflow on every lane
      for (int r = 0; r < 8; r++) rom[r] = {N{16'h0400}};
      for (int c = 0; c < 8; c++) xv[c] = 16'h7FFF;
      run_pass(1'b0, 0);
`ifdef COLUMN_MAC_SAT_EN
      exp_y = {N{16'h7FFF}};
`else
      exp_y = {N{16'h7FF8}};
`endif
      check("big_y", y_got, exp_y);
      check("big_ovf", 128'(ovf_got), 128'(1'b1));

      // per-lane weights +-0.5*j, x sums to 12 -> lanes 6,7 overflow
      for (int r = 0; r < 8; r++)
         rom[r] = {16'h8E00, 16'h0C00, 16'h8A00, 16'h0800,
                   16'h8600, 16'h0400, 16'h8200, 16'h0000};
      for (int c = 0; c < 8; c++) xv[c] = (c < 4) ? 16'h0400 : 16'h0800;
      run_pass(1'b0, 0);
`ifdef COLUMN_MAC_SAT_EN
      exp_y = {16'hFFFF, 16'h7FFF, 16'hF800, 16'h6000, 16'hC800, 16'h3000, 16'h9800, 16'h0000};
`else
      exp_y = {16'hA800, 16'h1000, 16'hF800, 16'h6000, 16'hC800, 16'h3000, 16'h9800, 16'h0000};
`endif
      check("lanes_y", y_got, exp_y);
      check("lanes_ovf", 128'(ovf_got), 128'(1'b1));

      // tiny negative sum truncates to zero (never -0); first x is -0
      for (int r = 0; r < 8; r++) rom[r] = {N{16'h0001}};
      for (int c = 0; c < 8; c++) xv[c] = (c == 0) ? 16'h8000 : 16'h8001;
      run_pass(1'b0, 0);
      check("trunc_y", y_got, {N{16'h0000}});
      check("trunc_ovf", 128'(ovf_got), 128'(1'b0));

      // stalls, ignored start pulses, and a 5-cycle y_ready hold
      for (int r = 0; r < 8; r++) rom[r] = (r % 2 == 0) ? {N{16'h8400}} : {N{16'h0400}};
      for (int c = 0; c < 8; c++) xv[c] = (c % 2 == 0) ? 16'h8400 : 16'h0400;
      run_pass(1'b1, 5);
      check("stall_y", y_got, {N{16'h2000}});
      check("stall_ovf", 128'(ovf_got), 128'(1'b0));

      // abort mid-RUN with a different vector, then a clean pass
      for (int c = 0; c < 8; c++) xv[c] = 16'h7FFF;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      x_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         x_in = xv[c];
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort_ctl", 128'({x_ready, y_valid, busy, ovf, addr}), 128'(0));
      check("abort_y", y, 128'(0));
      x_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 8; c++) xv[c] = (c % 2 == 0) ? 16'h8400 : 16'h0400;
      run_pass(1'b0, 0);
      check("fresh_y", y_got, {N{16'h2000}});
      check("fresh_ovf", 128'(ovf_got), 128'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
